// File: rtl/mem_read_ctrl_pkg.sv
// Shared types and size encodings for the load path.
// The load-masking stage uses the same size constants.
package mem_read_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CAPT,
        ERR
    } state_t;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    // Size 2'b11 is checked like a word.
    function automatic logic is_aligned(input logic [1:0] offset, input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 1'b1;
            SIZE_HALF: return ~offset[0];
            default:   return (offset == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_read_ctrl_if.sv
// Request, memory and result signals of the load-path read sequencer.
// The slave modport is the sequencer side.
interface mem_read_ctrl_if;

    logic        start;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic [31:0] mdr_out;
    logic [1:0]  ctrl_out;
    logic        busy;
    logic        done;
    logic        misaligned;

    modport master (
        output start, addr, size, mem_rdata,
        input  mem_addr, mem_rd, mdr_out, ctrl_out, busy, done, misaligned
    );

    modport slave (
        input  start, addr, size, mem_rdata,
        output mem_addr, mem_rd, mdr_out, ctrl_out, busy, done, misaligned
    );

endinterface

// File: rtl/mem_read_ctrl_lane_align.sv
// Combinational lane select: moves the addressed byte/halfword of a
// little-endian word down to bit 0 and zero-fills the rest.
module mem_lane_align
    import mem_read_ctrl_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    output logic [31:0] aligned
);

    always_comb begin
        aligned = data;
        case (size)
            SIZE_HALF: aligned = offset[1] ? {16'h0000, data[31:16]} : {16'h0000, data[15:0]};
            SIZE_BYTE: begin
                case (offset)
                    2'd0:    aligned = {24'h000000, data[7:0]};
                    2'd1:    aligned = {24'h000000, data[15:8]};
                    2'd2:    aligned = {24'h000000, data[23:16]};
                    default: aligned = {24'h000000, data[31:24]};
                endcase
            end
            default:   aligned = data;
        endcase
    end

endmodule

// File: rtl/mem_read_ctrl.sv
// Multi-cycle memory read sequencer: one word-aligned read, fixed latency wait,
// lane alignment into the MDR, size handed to the load-masking stage.
module mem_read_ctrl
    import mem_read_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_read_ctrl_if.slave bus
);

    localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic [1:0]  lat_off;
    logic [1:0]  lat_size;
    logic [31:0] aligned;

    mem_lane_align u_align (
        .data    (bus.mem_rdata),
        .offset  (lat_off),
        .size    (lat_size),
        .aligned (aligned)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            lat_off        <= '0;
            lat_size       <= SIZE_WORD;
            bus.mem_addr   <= '0;
            bus.mem_rd     <= 1'b0;
            bus.mdr_out    <= '0;
            bus.ctrl_out   <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.misaligned <= 1'b0;
        end else begin
            bus.mem_rd     <= 1'b0;
            bus.done       <= 1'b0;
            bus.misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (is_aligned(bus.addr[1:0], bus.size)) begin
                            state        <= REQ;
                            bus.mem_addr <= {bus.addr[31:2], 2'b00};
                            lat_off      <= bus.addr[1:0];
                            lat_size     <= bus.size;
                            bus.mem_rd   <= 1'b1;
                        end else begin
                            state          <= ERR;
                            bus.misaligned <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    cnt   <= LAT_INIT;
                    state <= WAIT;
                end
                // The sampled word goes straight through the aligner into the MDR,
                // so the MDR doubles as the holding register and done lines up with CAPT.
                WAIT: begin
                    if (cnt == '0) begin
                        bus.mdr_out  <= aligned;
                        bus.ctrl_out <= lat_size;
                        bus.done     <= 1'b1;
                        state        <= CAPT;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                CAPT, ERR: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_ctrl.sv
// Bench for mem_read_ctrl at MEM_LATENCY 1 and 3: timeline model per instance
// checked every cycle, plus directed literal checks and random traffic.
module tb_mem_read_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] next_rdata;
    int          cyc;
    int          tests;
    int          fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit legal_req(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'b10) return 1'b1;
        if (s == 2'b01) return (a % 2) == 0;
        return (a % 4) == 0;
    endfunction

    function automatic logic [31:0] lane_value(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] s);
        logic [31:0] shifted;
        shifted = w >> (8 * (a % 4));
        if (s == 2'b01) return shifted & 32'h0000_FFFF;
        if (s == 2'b10) return shifted & 32'h0000_00FF;
        return w;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int LAT = (gi == 0) ? 1 : 3;

        mem_read_ctrl_if bus ();
        logic [31:0] rdata;

        assign bus.start     = start;
        assign bus.addr      = addr;
        assign bus.size      = size;
        assign bus.mem_rdata = rdata;

        logic        mon_rd, mon_done, mon_mis, mon_busy;
        logic [31:0] mon_mdr, mon_maddr;
        logic [1:0]  mon_ctrl;
        assign mon_rd    = bus.mem_rd;
        assign mon_done  = bus.done;
        assign mon_mis   = bus.misaligned;
        assign mon_busy  = bus.busy;
        assign mon_mdr   = bus.mdr_out;
        assign mon_maddr = bus.mem_addr;
        assign mon_ctrl  = bus.ctrl_out;

        mem_read_ctrl #(.MEM_LATENCY(LAT)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        // Timeline model: each accepted request schedules its rd, done and
        // idle cycles; outputs follow from where the current cycle falls.
        int          e, rd_at, done_at, mis_at, free_at;
        logic [31:0] m_maddr, m_mdr, p_maddr, p_mdr, word;
        logic [1:0]  m_ctrl, p_ctrl;

        initial begin
            e = 0; rd_at = -100; done_at = -100; mis_at = -100; free_at = 0;
            m_maddr = '0; m_mdr = '0; m_ctrl = '0;
            p_maddr = '0; p_mdr = '0; p_ctrl = '0; word = '0;
            rdata = '0;
            forever begin
                @(posedge clk);
                e++;
                if (!reset) begin
                    rd_at = -100; done_at = -100; mis_at = -100; free_at = e;
                    m_maddr = '0; m_mdr = '0; m_ctrl = '0;
                end else if (start && free_at <= e - 1) begin
                    if (legal_req(addr, size)) begin
                        rd_at   = e;
                        done_at = e + LAT + 1;
                        free_at = e + LAT + 2;
                        p_maddr = addr - (addr % 4);
                        word    = next_rdata;
                        p_mdr   = lane_value(word, addr, size);
                        p_ctrl  = size;
                    end else begin
                        mis_at  = e;
                        free_at = e + 1;
                    end
                end
                if (e == rd_at) m_maddr = p_maddr;
                if (e == done_at) begin
                    m_mdr  = p_mdr;
                    m_ctrl = p_ctrl;
                end
                #1;
                rdata = (e == rd_at + LAT) ? word : $urandom();
                check($sformatf("L%0d mem_rd", LAT), 32'(bus.mem_rd), 32'(e == rd_at));
                check($sformatf("L%0d done", LAT), 32'(bus.done), 32'(e == done_at));
                check($sformatf("L%0d misaligned", LAT), 32'(bus.misaligned), 32'(e == mis_at));
                check($sformatf("L%0d busy", LAT), 32'(bus.busy), 32'(e < free_at));
                check($sformatf("L%0d mem_addr", LAT), bus.mem_addr, m_maddr);
                check($sformatf("L%0d mdr_out", LAT), bus.mdr_out, m_mdr);
                check($sformatf("L%0d ctrl_out", LAT), 32'(bus.ctrl_out), 32'(m_ctrl));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic [31:0] w,
                         output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while ((g[0].mon_busy || g[1].mon_busy) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle before start", 32'(g[0].mon_busy | g[1].mon_busy), 32'd0);
        start = 1'b1; addr = a; size = s; next_rdata = w;
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic run(input logic [31:0] a, input logic [1:0] s, input logic [31:0] w,
                       input logic [31:0] em, input logic [31:0] ema, input bit poke);
        int acc, nrd0, nrd1;
        bit s0, s1;
        issue(a, s, w, acc);
        check("L1 rd at T+1", 32'(g[0].mon_rd), 32'd1);
        check("L3 rd at T+1", 32'(g[1].mon_rd), 32'd1);
        check("L1 mem_addr aligned", g[0].mon_maddr, ema);
        check("L3 mem_addr aligned", g[1].mon_maddr, ema);
        @(negedge clk);
        start = 1'b0;
        s0 = 0; s1 = 0; nrd0 = 0; nrd1 = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 0 && poke) begin
                start = 1'b1; addr = 32'h0000_3000; size = 2'b00;
            end else begin
                start = 1'b0;
            end
            if (g[0].mon_rd) nrd0++;
            if (g[1].mon_rd) nrd1++;
            if (!s0 && g[0].mon_done) begin
                s0 = 1;
                check("L1 done latency", 32'(cyc - acc + 1), 32'd3);
                check("L1 mdr literal", g[0].mon_mdr, em);
                check("L1 ctrl literal", 32'(g[0].mon_ctrl), 32'(s));
            end
            if (!s1 && g[1].mon_done) begin
                s1 = 1;
                check("L3 done latency", 32'(cyc - acc + 1), 32'd5);
                check("L3 mdr literal", g[1].mon_mdr, em);
                check("L3 ctrl literal", 32'(g[1].mon_ctrl), 32'(s));
            end
            if (s0 && s1) break;
        end
        start = 1'b0;
        check("L1 done seen", 32'(s0), 32'd1);
        check("L3 done seen", 32'(s1), 32'd1);
        check("L1 extra mem_rd", 32'(nrd0), 32'd0);
        check("L3 extra mem_rd", 32'(nrd1), 32'd0);
    endtask

    task automatic mis(input logic [31:0] a, input logic [1:0] s);
        int acc;
        logic [31:0] prev0, prev1;
        prev0 = g[0].mon_mdr;
        prev1 = g[1].mon_mdr;
        issue(a, s, 32'hBAD0_BAD0, acc);
        check("L1 misaligned pulse", 32'(g[0].mon_mis), 32'd1);
        check("L3 misaligned pulse", 32'(g[1].mon_mis), 32'd1);
        check("L1 no rd on misaligned", 32'(g[0].mon_rd), 32'd0);
        check("L3 no rd on misaligned", 32'(g[1].mon_rd), 32'd0);
        check("L1 mdr held", g[0].mon_mdr, prev0);
        check("L3 mdr held", g[1].mon_mdr, prev1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic reset_in_wait();
        int acc, nd;
        issue(32'h0000_4008, 2'b00, 32'h0BAD_F00D, acc);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("L1 busy after reset", 32'(g[0].mon_busy), 32'd0);
        check("L3 busy after reset", 32'(g[1].mon_busy), 32'd0);
        check("L1 mdr after reset", g[0].mon_mdr, 32'd0);
        check("L3 mem_addr after reset", g[1].mon_maddr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (g[0].mon_done || g[1].mon_done) nd++;
        end
        check("done after reset abort", 32'(nd), 32'd0);
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b0; start = 1'b0; addr = '0; size = '0; next_rdata = '0;
        repeat (3) @(negedge clk);
        check("L1 reset mdr", g[0].mon_mdr, 32'd0);
        check("L3 reset busy", 32'(g[1].mon_busy), 32'd0);
        reset = 1'b1;

        run(32'h0000_1004, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_1004, 0);
        run(32'h0000_2000, 2'b10, 32'h1122_3344, 32'h0000_0044, 32'h0000_2000, 0);
        run(32'h0000_2001, 2'b10, 32'h1122_3344, 32'h0000_0033, 32'h0000_2000, 0);
        run(32'h0000_2002, 2'b10, 32'h1122_3344, 32'h0000_0022, 32'h0000_2000, 0);
        run(32'h0000_2003, 2'b10, 32'h1122_3344, 32'h0000_0011, 32'h0000_2000, 0);
        run(32'h0000_2002, 2'b01, 32'hCAFE_0BAD, 32'h0000_CAFE, 32'h0000_2000, 0);
        mis(32'h0000_0101, 2'b00);
        run(32'h0000_0100, 2'b00, 32'h1234_5678, 32'h1234_5678, 32'h0000_0100, 0);
        mis(32'h0000_0103, 2'b01);
        run(32'h0000_0102, 2'b01, 32'hA5A5_5A5A, 32'h0000_A5A5, 32'h0000_0100, 0);
        run(32'h0000_0000, 2'b11, 32'h0F0E_0D0C, 32'h0F0E_0D0C, 32'h0000_0000, 0);
        run(32'h0000_3004, 2'b10, 32'h5566_7788, 32'h0000_0088, 32'h0000_3004, 1);
        reset_in_wait();

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            reset      = ($urandom_range(63) != 0);
            start      = ($urandom_range(2) == 0);
            addr       = $urandom();
            size       = 2'($urandom_range(3));
            next_rdata = $urandom();
        end
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_read_ctrl.md
# mem_read_ctrl

Multi-cycle memory read sequencer for the load path. It issues one word-aligned read to data memory and waits a fixed memory latency. It then shifts the addressed byte or halfword down to bit 0, registers the result as the memory data register (MDR), and hands the MDR plus the access size to the downstream load-masking stage. That stage zero-extends the low 8/16 bits, so this block owns lane selection and alignment checking.

## Interface
Parameters:
- MEM_LATENCY, default 1: cycles from the `mem_rd` cycle to the cycle `mem_rdata` is valid; legal range 1..7.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  request a load; sampled only in IDLE
- addr  in  32  byte address of the load
- size  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word
- mem_addr  out  32  word-aligned address to memory, {addr[31:2],2'b00}
- mem_rd  out  1  read strobe, exactly one cycle per accepted request
- mem_rdata  in  32  memory read data
- mdr_out  out  32  lane-aligned read data to the load-masking stage
- ctrl_out  out  2  registered `size` of the last completed load, drives the load stage control
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: `mdr_out` and `ctrl_out` updated this cycle
- misaligned  out  1  one-cycle pulse: request rejected for alignment

## Operation
- Byte lanes are little-endian: byte offset k occupies bits [8k+7:8k].
- Alignment rule: a word needs addr[1:0]==00; a halfword needs addr[0]==0; a byte is always legal; size 11 follows the word rule.
- FSM states: IDLE, REQ, WAIT, CAPT, ERR.
- IDLE: when start=1 and the request is aligned, latch addr and size and go to REQ. When start=1 and the request is misaligned, go to ERR. Otherwise stay in IDLE.
- REQ: mem_rd=1 and mem_addr is driven. Load the latency counter with MEM_LATENCY-1, then go to WAIT.
- WAIT: decrement the counter. When the counter is 0, sample mem_rdata into an internal holding register, then go to CAPT. With MEM_LATENCY=1, WAIT lasts exactly one cycle.
- CAPT: mdr_out <= aligned data, ctrl_out <= latched size, done=1, then go to IDLE.
- ERR: misaligned=1; mdr_out and ctrl_out are unchanged; go to IDLE.
- Alignment of the captured data:
  - word: data unchanged.
  - halfword: offset 0 gives {16'b0, d[15:0]}; offset 2 gives {16'b0, d[31:16]}.
  - byte: {24'b0, d[8k+7:8k]}, where k = addr[1:0].
- start is ignored while busy=1. No queuing.
- mem_addr holds the latched aligned address from REQ until the next accepted request. It is 0 after reset.

## Timing
- start accepted at cycle T. REQ (mem_rd=1) at T+1. mem_rdata sampled at T+1+MEM_LATENCY. done=1 with the new mdr_out and ctrl_out at T+2+MEM_LATENCY.
- Total request latency is MEM_LATENCY+2 cycles.
- A misaligned start at T gives misaligned=1 at T+1 and IDLE at T+2. No mem_rd is issued.
- A new start is accepted at the earliest in the cycle after done or misaligned, because IDLE is re-entered then.
- Reset values (reset=0 at a rising edge): state IDLE, mdr_out 0, ctrl_out 00, mem_addr 0, mem_rd 0, busy 0, done 0, misaligned 0.
- Reset asserted mid-operation, in any state, aborts the access. No done pulse follows. A read already issued is discarded.
- done and misaligned are never high in the same cycle. mem_rd is never high outside REQ.

## Structure
- Shared package contents:
  - state enum: IDLE, REQ, WAIT, CAPT, ERR.
  - size constants: SIZE_WORD=2'b00, SIZE_HALF=2'b01, SIZE_BYTE=2'b10.
  - these size constants are shared with the load-masking stage.
- Sub-module mem_lane_align: purely combinational, inputs (data, offset[1:0], size), output the aligned 32-bit value. It holds the shift and select logic so that it can be unit-tested separately.
- Latency counter is 3 bits wide.

## Test plan
- Word load, MEM_LATENCY=1: addr=0x0000_1004, size=00, mem_rdata=0xDEAD_BEEF. Required: mem_rd at T+1 with mem_addr=0x0000_1004; done at T+3; mdr_out=0xDEAD_BEEF; ctrl_out=00.
- Byte lanes: mem_rdata=0x1122_3344, size=10, addr low bits 0..3. Required mdr_out = 0x44, 0x33, 0x22, 0x11 respectively; mem_addr is word-aligned in every case.
- Halfword at offset 2, MEM_LATENCY=3: addr=0x0000_2002, mem_rdata=0xCAFE_0BAD. Required: mdr_out=0x0000_CAFE; done exactly 5 cycles after start.
- Misaligned requests: word at addr=0x...01, then half at addr=0x...03. Required for each: misaligned pulse at T+1, no mem_rd, mdr_out unchanged; then an aligned request at T+2 is accepted.
- Busy and reset: a second start during WAIT is ignored (one mem_rd, one done). Reset=0 during WAIT gives IDLE and zeroed outputs on the next edge, with no done pulse afterwards.
